// File: rtl/nv_ram_fifo_ctrl_512x64.sv
// Valid/ready FIFO controller for an external 512x64 1R1W flop-RAM with a one-cycle read.
// Pointers, occupancy and a 2-entry output skid buffer let it sustain one push and one pop per cycle.
module nv_ram_fifo_ctrl_512x64 #(
    parameter int DW = 64,
    parameter int AW = 9
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          fifo_clr,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW:0]   fifo_cnt,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(1 << AW);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_cnt;
    logic [AW:0]   ram_cnt_nxt;
    logic          inflight;
    logic [1:0]    skid_cnt;
    logic [1:0]    skid_cnt_nxt;
    logic [DW-1:0] skid1;
    logic [2:0]    skid_load;
    logic          push;
    logic          pop;
    logic          issue;
    logic          capture;

    // A read may only be issued if its data is guaranteed a skid slot when it lands.
    always_comb begin
        push         = wr_pvld & wr_prdy & ~fifo_clr;
        pop          = rd_pvld & rd_prdy & ~fifo_clr;
        skid_load    = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, rd_pvld & rd_prdy};
        issue        = (ram_cnt != '0) && (skid_load < 3'd2) && !fifo_clr;
        capture      = inflight & ~fifo_clr;
        ram_cnt_nxt  = ram_cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, issue};
        skid_cnt_nxt = skid_cnt + {1'b0, capture} - {1'b0, pop};
    end

    assign ram_we   = push;
    assign ram_wa   = wr_ptr;
    assign ram_di   = wr_pd;
    assign ram_re   = issue;
    assign ram_ra   = rd_ptr;
    assign fifo_cnt = ram_cnt + {{AW{1'b0}}, inflight} + {{(AW-1){1'b0}}, skid_cnt};

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            skid_cnt <= 2'd0;
            rd_pvld  <= 1'b0;
            wr_prdy  <= 1'b0;
        end else if (fifo_clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            skid_cnt <= 2'd0;
            rd_pvld  <= 1'b0;
            wr_prdy  <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + {{(AW-1){1'b0}}, push};
            rd_ptr   <= rd_ptr + {{(AW-1){1'b0}}, issue};
            ram_cnt  <= ram_cnt_nxt;
            inflight <= issue;
            skid_cnt <= skid_cnt_nxt;
            rd_pvld  <= (skid_cnt_nxt != 2'd0);
            wr_prdy  <= (ram_cnt_nxt < FULL_CNT);
        end
    end

    // Skid head lives in rd_pd; skid1 holds the second entry behind it.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rd_pd <= '0;
        end else if (capture && ((skid_cnt == 2'd0) || (skid_cnt == 2'd1 && pop))) begin
            rd_pd <= ram_dout;
        end else if (pop && skid_cnt == 2'd2) begin
            rd_pd <= skid1;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (capture && ((skid_cnt == 2'd1 && !pop) || (skid_cnt == 2'd2 && pop))) begin
            skid1 <= ram_dout;
        end
    end

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_512x64.sv
// Bench for nv_ram_fifo_ctrl_512x64: behavioural RAM, queue scoreboard fed by accepted pushes,
// and a monitor that checks pops, occupancy and RAM-port legality every cycle.
module tb_nv_ram_fifo_ctrl_512x64;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fifo_clr;
    logic        wr_pvld;
    logic        wr_prdy;
    logic [63:0] wr_pd;
    logic        rd_pvld;
    logic        rd_prdy;
    logic [63:0] rd_pd;
    logic [9:0]  fifo_cnt;
    logic [8:0]  ram_wa;
    logic        ram_we;
    logic [63:0] ram_di;
    logic [8:0]  ram_ra;
    logic        ram_re;
    logic [63:0] ram_dout;

    always #5 clk = ~clk;

    nv_ram_fifo_ctrl_512x64 #(.DW(64), .AW(9)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .fifo_clr       (fifo_clr),
        .wr_pvld        (wr_pvld),
        .wr_prdy        (wr_prdy),
        .wr_pd          (wr_pd),
        .rd_pvld        (rd_pvld),
        .rd_prdy        (rd_prdy),
        .rd_pd          (rd_pd),
        .fifo_cnt       (fifo_cnt),
        .ram_wa         (ram_wa),
        .ram_we         (ram_we),
        .ram_di         (ram_di),
        .ram_ra         (ram_ra),
        .ram_re         (ram_re),
        .ram_dout       (ram_dout)
    );

    // Flop-RAM: registered read address, combinational read mux.
    logic [63:0] mem [0:511];
    logic [8:0]  ra_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
    end
    assign ram_dout = mem[ra_q];

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    int model_cnt = 0;
    int pop_total = 0;
    int we_total = 0;
    int re_total = 0;
    int pop_since_clr = 0;
    bit m_push;
    bit m_pop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard feed: every accepted push is an expected output, in order.
    always @(negedge clk) begin
        if (!rstn || fifo_clr) exp_q.delete();
        else if (wr_pvld && wr_prdy) exp_q.push_back(wr_pd);
    end

    always @(negedge clk) begin
        if (!rstn) begin
            model_cnt = 0;
            we_total = 0;
            re_total = 0;
            pop_since_clr = 0;
        end else begin
            m_push = wr_pvld && wr_prdy && !fifo_clr;
            m_pop  = rd_pvld && rd_prdy && !fifo_clr;
            chk("fifo_cnt", 64'(fifo_cnt), 64'(model_cnt));
            chk("ram_we", 64'(ram_we), 64'(m_push));
            if (ram_we) chk("ram_wa", 64'(ram_wa), 64'(we_total % 512));
            if (ram_re) begin
                chk("re_has_data", 64'(re_total < we_total), 64'(1));
                chk("re_skid_room", 64'((re_total - pop_since_clr - int'(m_pop)) < 2), 64'(1));
                chk("ram_ra", 64'(ram_ra), 64'(re_total % 512));
            end
            if (m_pop) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_underflow actual=0x%0h required=none at %0t", rd_pd, $time);
                end else begin
                    chk("rd_pd", rd_pd, exp_q.pop_front());
                end
            end
            if (fifo_clr) begin
                model_cnt = 0;
                we_total = 0;
                re_total = 0;
                pop_since_clr = 0;
            end else begin
                model_cnt += int'(m_push) - int'(m_pop);
                we_total += int'(ram_we);
                re_total += int'(ram_re);
                pop_since_clr += int'(m_pop);
            end
            pop_total += int'(m_pop);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Keep a pending push valid until it is taken, then drop wr_pvld.
    task automatic finish_push();
        int n = 0;
        rd_prdy = 1'b1;
        if (wr_pvld) begin
            while (!wr_prdy && n < 600) begin step(); n++; end
            chk("push_complete", 64'(wr_prdy), 64'(1));
            step();
        end
        wr_pvld = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        while (fifo_cnt != 0 && n < 700) begin step(); n++; end
        step();
        rd_prdy = 1'b0;
        chk({name, "_cnt"}, 64'(fifo_cnt), 64'(0));
        chk({name, "_sb"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bit acc;
        int sent;
        int cyc;
        int pops0;
        int rd_pct;
        acc = 1'b0;
        rstn = 1'b0;
        fifo_clr = 1'b0;
        wr_pvld = 1'b0;
        wr_pd = '0;
        rd_prdy = 1'b0;

        // Reset
        repeat (5) step();
        chk("rst_wr_prdy", 64'(wr_prdy), 64'(0));
        chk("rst_rd_pvld", 64'(rd_pvld), 64'(0));
        chk("rst_rd_pd", rd_pd, 64'(0));
        chk("rst_fifo_cnt", 64'(fifo_cnt), 64'(0));
        chk("rst_ram_we", 64'(ram_we), 64'(0));
        chk("rst_ram_re", 64'(ram_re), 64'(0));
        rstn = 1'b1;
        step();
        chk("rel_wr_prdy", 64'(wr_prdy), 64'(1));
        chk("rel_rd_pvld", 64'(rd_pvld), 64'(0));

        // Single push latency
        wr_pvld = 1'b1;
        wr_pd = 64'hDEAD_BEEF_0000_0001;
        step();
        wr_pvld = 1'b0;
        chk("single_ram_re", 64'(ram_re), 64'(1));
        chk("single_ram_ra", 64'(ram_ra), 64'(0));
        chk("single_cnt1", 64'(fifo_cnt), 64'(1));
        step();
        chk("single_t2_pvld", 64'(rd_pvld), 64'(0));
        step();
        chk("single_t3_pvld", 64'(rd_pvld), 64'(1));
        chk("single_t3_pd", rd_pd, 64'hDEAD_BEEF_0000_0001);
        rd_prdy = 1'b1;
        step();
        rd_prdy = 1'b0;
        chk("single_cnt0", 64'(fifo_cnt), 64'(0));
        chk("single_pvld0", 64'(rd_pvld), 64'(0));

        // Streaming 2000 back-to-back
        sent = 0;
        cyc = 0;
        pops0 = pop_total;
        rd_prdy = 1'b1;
        wr_pvld = 1'b1;
        wr_pd = 64'h1000_0000_0000_0000;
        while (sent < 2000 && cyc < 2100) begin
            acc = wr_prdy;
            step();
            cyc++;
            if (acc) begin sent++; wr_pd = 64'h1000_0000_0000_0000 + 64'(sent); end
        end
        wr_pvld = 1'b0;
        chk("stream_cycles", 64'(cyc), 64'(2000));
        chk("stream_rate", 64'((pop_total - pops0) >= 1995), 64'(1));
        drain("stream_drain");

        // Full
        sent = 0;
        rd_prdy = 1'b0;
        wr_pvld = 1'b1;
        wr_pd = 64'h2000_0000_0000_0000;
        for (int c = 0; c < 600; c++) begin
            acc = wr_prdy;
            step();
            if (acc) begin sent++; wr_pd = 64'h2000_0000_0000_0000 + 64'(sent); end
        end
        chk("full_accepted", 64'(sent), 64'(514));
        chk("full_cnt", 64'(fifo_cnt), 64'(514));
        chk("full_wr_prdy", 64'(wr_prdy), 64'(0));
        rd_prdy = 1'b1;
        step();
        rd_prdy = 1'b0;
        cyc = 0;
        while (!wr_prdy && cyc < 2) begin step(); cyc++; end
        chk("full_reopen", 64'(wr_prdy), 64'(1));
        finish_push();
        drain("full_drain");

        // Random backpressure
        acc = 1'b0;
        wr_pvld = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            rd_pct = ((c / 1000) % 2 == 1) ? 30 : 80;
            if (!wr_pvld || acc) begin
                wr_pvld = ($urandom_range(0, 3) != 0);
                wr_pd = {$urandom, $urandom};
            end
            rd_prdy = ($urandom_range(0, 99) < rd_pct);
            acc = wr_pvld && wr_prdy;
            step();
        end
        finish_push();
        drain("rand_drain");

        // fifo_clr with a read in flight
        sent = 0;
        cyc = 0;
        rd_prdy = 1'b0;
        wr_pvld = 1'b1;
        wr_pd = 64'h3000_0000_0000_0000;
        while (sent < 300 && cyc < 400) begin
            acc = wr_prdy;
            step();
            cyc++;
            if (acc) begin sent++; wr_pd = 64'h3000_0000_0000_0000 + 64'(sent); end
        end
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        step();
        rd_prdy = 1'b0;
        fifo_clr = 1'b1;
        wr_pvld = 1'b1;
        wr_pd = 64'hAA;
        step();
        fifo_clr = 1'b0;
        wr_pvld = 1'b0;
        chk("clr_cnt", 64'(fifo_cnt), 64'(0));
        chk("clr_rd_pvld", 64'(rd_pvld), 64'(0));
        chk("clr_wr_prdy", 64'(wr_prdy), 64'(0));
        step();
        chk("clr_reopen", 64'(wr_prdy), 64'(1));
        wr_pvld = 1'b1;
        wr_pd = 64'h55;
        step();
        wr_pvld = 1'b0;
        step();
        step();
        chk("clr_post_pvld", 64'(rd_pvld), 64'(1));
        chk("clr_post_pd", rd_pd, 64'h55);
        rd_prdy = 1'b1;
        step();
        rd_prdy = 1'b0;
        chk("clr_post_cnt", 64'(fifo_cnt), 64'(0));

        // Asynchronous reset mid-traffic
        wr_pvld = 1'b1;
        for (int c = 0; c < 20; c++) begin
            wr_pd = 64'h4000_0000_0000_0000 + 64'(c);
            step();
        end
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_cnt", 64'(fifo_cnt), 64'(0));
        chk("arst_rd_pvld", 64'(rd_pvld), 64'(0));
        chk("arst_wr_prdy", 64'(wr_prdy), 64'(0));
        chk("arst_ram_re", 64'(ram_re), 64'(0));
        chk("arst_ram_we", 64'(ram_we), 64'(0));
        wr_pvld = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        step();
        chk("arst_rel_wr_prdy", 64'(wr_prdy), 64'(1));
        wr_pvld = 1'b1;
        wr_pd = 64'h0123_4567_89AB_CDEF;
        step();
        wr_pvld = 1'b0;
        drain("arst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
